// File: rtl/avalon_mem_master_pkg.sv
// Shared types for the Avalon-MM initiator: data word, access size and FSM state.
package avalon_mem_master_pkg;

  typedef logic [31:0] size_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RDATA = 2'd2,
    RESP  = 2'd3
  } state_t;

  // A half must sit on an even byte, a word on a multiple of four.
  function automatic logic is_misaligned(mem_size_t size, logic [1:0] offset);
    return ((size == HALF) && offset[0]) || ((size == WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/avalon_mem_master_if.sv
// Core request/response and Avalon-MM signals of the memory initiator.
interface avalon_mem_master_if;
  import avalon_mem_master_pkg::*;

  // Handshake: a request is taken on a rising edge where req_valid and req_ready
  // are both high; resp_valid is a single-cycle completion pulse with no back-pressure.
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  mem_size_t  req_size;
  logic       req_signed;
  size_t      req_addr;
  size_t      req_wdata;
  logic       resp_valid;
  size_t      resp_rdata;
  logic       resp_err;
  size_t      avm_address;
  logic       avm_read;
  logic       avm_write;
  logic [3:0] avm_byteenable;
  size_t      avm_writedata;
  size_t      avm_readdata;
  logic       avm_waitrequest;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  avm_readdata, avm_waitrequest,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output avm_readdata, avm_waitrequest,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
  );

endinterface

// File: rtl/avalon_mem_master_mem_lane_align.sv
// Little-endian lane steering: byteenable and store shift, load extract and extend.
module mem_lane_align
  import avalon_mem_master_pkg::*;
(
  input  mem_size_t  size,
  input  logic [1:0] offset,
  input  logic       is_signed,
  input  size_t      wdata,
  input  size_t      rdata,
  output logic [3:0] byteenable,
  output size_t      writedata,
  output size_t      load_data
);

  size_t shifted;

  always_comb begin
    byteenable = 4'b0000;
    case (size)
      BYTE:    byteenable = 4'b0001 << offset;
      HALF:    byteenable = offset[1] ? 4'b1100 : 4'b0011;
      WORD:    byteenable = 4'b1111;
      default: byteenable = 4'b0000;
    endcase
  end

  always_comb begin
    writedata = wdata << {offset, 3'b000};
    shifted   = rdata >> {offset, 3'b000};
    case (size)
      BYTE:    load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      HALF:    load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/avalon_mem_master.sv
// Single-outstanding Avalon-MM initiator: one load/store per request, waitrequest
// honoured, readdata taken one cycle after the slave accepts the read.
module avalon_mem_master
  import avalon_mem_master_pkg::*;
#(
  parameter size_t RESET_ADDR = 32'hBFC00000
) (
  input  logic                       clk,
  input  logic                       reset,
  avalon_mem_master_if.master        bus,
  output state_t                     debug_state
);

  state_t     state, state_next;
  logic       write_q;
  mem_size_t  size_q;
  logic       signed_q;
  size_t      addr_q;
  size_t      wdata_q;
  size_t      rdata_q;
  logic       err_q;
  logic [3:0] lane_be;
  size_t      lane_wdata;
  size_t      lane_load;

  mem_lane_align u_align (
    .size       (size_q),
    .offset     (addr_q[1:0]),
    .is_signed  (signed_q),
    .wdata      (wdata_q),
    .rdata      (bus.avm_readdata),
    .byteenable (lane_be),
    .writedata  (lane_wdata),
    .load_data  (lane_load)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      write_q  <= 1'b0;
      size_q   <= BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && bus.req_valid) begin
        write_q  <= bus.req_write;
        size_q   <= bus.req_size;
        signed_q <= bus.req_signed;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        rdata_q  <= '0;
        err_q    <= is_misaligned(bus.req_size, bus.req_addr[1:0]);
      end
      if (state == RDATA) rdata_q <= lane_load;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req_valid)
          state_next = is_misaligned(bus.req_size, bus.req_addr[1:0]) ? RESP : BUS;
      end
      BUS: begin
        if (!bus.avm_waitrequest) state_next = write_q ? RESP : RDATA;
      end
      RDATA:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset drops the strobes at once.
  assign bus.req_ready      = (state == IDLE);
  assign bus.avm_read       = (state == BUS) && !write_q;
  assign bus.avm_write      = (state == BUS) && write_q;
  assign bus.avm_address    = (state == BUS) ? {addr_q[31:2], 2'b00} : RESET_ADDR;
  assign bus.avm_byteenable = (state == BUS) ? lane_be : 4'b0000;
  assign bus.avm_writedata  = (state == BUS) ? lane_wdata : '0;
  assign bus.resp_valid     = (state == RESP);
  assign bus.resp_rdata     = (state == RESP) ? rdata_q : '0;
  assign bus.resp_err       = (state == RESP) && err_q;
  assign debug_state        = state;

endmodule

// File: tb/tb_avalon_mem_master.sv
// Self-checking bench for avalon_mem_master: directed loads/stores, waitrequest,
// misalignment and mid-transfer reset, then randomized traffic against a byte model.
module tb_avalon_mem_master;
  import avalon_mem_master_pkg::*;

  localparam size_t BASE = 32'hBFC00000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  avalon_mem_master_if bus();
  state_t debug_state;

  avalon_mem_master #(.RESET_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (rst),
    .bus         (bus),
    .debug_state (debug_state)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(int i);
    if (i == 1) return 32'h8899AABB;
    return 32'(i) * 32'h9E3779B9 + 32'h01234567;
  endfunction

  // ---------------- slave memory (16 words at BASE) ----------------
  logic [31:0] slv_mem [16];
  int wait_cfg = 0;
  int wait_cnt;
  bit mem_loaded = 1'b0;

  assign bus.avm_waitrequest = (bus.avm_read || bus.avm_write) && (wait_cnt < wait_cfg);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt         <= 0;
      bus.avm_readdata <= '0;
      if (!mem_loaded) begin
        for (int i = 0; i < 16; i++) slv_mem[i] <= init_word(i);
        mem_loaded <= 1'b1;
      end
    end else if (bus.avm_read || bus.avm_write) begin
      if (bus.avm_waitrequest) begin
        wait_cnt <= wait_cnt + 1;
      end else begin
        wait_cnt <= 0;
        if (bus.avm_read) bus.avm_readdata <= slv_mem[bus.avm_address[5:2]];
        else
          for (int k = 0; k < 4; k++)
            if (bus.avm_byteenable[k])
              slv_mem[bus.avm_address[5:2]][8*k +: 8] <= bus.avm_writedata[8*k +: 8];
      end
    end
  end

  // ---------------- reference model: byte-addressed memory ----------------
  logic [7:0] ref_bytes [64];

  function automatic int nbytes(mem_size_t sz);
    return (sz == BYTE) ? 1 : (sz == HALF) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(mem_size_t sz, logic sg, size_t addr);
    int n;
    logic [31:0] v;
    n = nbytes(sz);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[addr[5:0] + 6'(i)];
    if (n < 4 && sg && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
    return v;
  endfunction

  task automatic ref_store(mem_size_t sz, size_t addr, size_t wd);
    for (int i = 0; i < nbytes(sz); i++) ref_bytes[addr[5:0] + 6'(i)] = wd[8*i +: 8];
  endtask

  // ---------------- driver: one request, observe bus and response ----------------
  task automatic do_req(input string tag, input logic wr, input mem_size_t sz, input logic sg,
                        input size_t addr, input size_t wd, input int waits);
    int n, a, exp_lat, got_lat, rd_cyc, wr_cyc, g;
    bit mis, stable_bad, wd_ok;
    logic [3:0] exp_be, seen_be;
    size_t seen_wd, got_rdata;
    logic got_err;
    logic [31:0] exp_rdata;

    n = nbytes(sz);
    a = int'(addr[1:0]);
    mis = (addr % n) != 0;
    exp_be = '0;
    if (!mis) for (int i = 0; i < n; i++) exp_be[a + i] = 1'b1;
    exp_lat = mis ? 1 : ((wr ? 2 : 3) + waits);
    exp_q.push_back((mis || wr) ? 32'h0 : ref_load(sz, sg, addr));

    @(negedge clk);
    g = 0;
    while (!bus.req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);

    wait_cfg       = waits;
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;

    got_lat = 0; rd_cyc = 0; wr_cyc = 0; stable_bad = 0;
    seen_be = '0; seen_wd = '0; got_rdata = '0; got_err = 1'b0;
    for (int c = 1; c <= 40 && got_lat == 0; c++) begin
      @(negedge clk);
      if (bus.avm_read || bus.avm_write) begin
        if (bus.avm_read) rd_cyc++;
        if (bus.avm_write) wr_cyc++;
        if (rd_cyc + wr_cyc == 1) begin
          seen_be = bus.avm_byteenable;
          seen_wd = bus.avm_writedata;
        end else if (bus.avm_byteenable !== seen_be || bus.avm_writedata !== seen_wd) begin
          stable_bad = 1;
        end
        if (bus.avm_address !== {addr[31:2], 2'b00}) stable_bad = 1;
      end
      if (bus.resp_valid) begin
        got_lat   = c;
        got_rdata = bus.resp_rdata;
        got_err   = bus.resp_err;
      end
      if (c == 1) begin
        // Garbage while busy must be ignored.
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
      end
    end

    check({tag, "_latency"}, 32'(got_lat), 32'(exp_lat));
    check({tag, "_rd_cycles"}, 32'(rd_cyc), (!mis && !wr) ? 32'(waits + 1) : 32'd0);
    check({tag, "_wr_cycles"}, 32'(wr_cyc), (!mis && wr) ? 32'(waits + 1) : 32'd0);
    check({tag, "_stable"}, 32'(stable_bad), 32'd0);
    if (!mis) check({tag, "_be"}, 32'(seen_be), 32'(exp_be));
    if (!mis && wr) begin
      wd_ok = 1;
      for (int i = 0; i < n; i++)
        if (seen_wd[8*(a+i) +: 8] !== wd[8*i +: 8]) wd_ok = 0;
      check({tag, "_wdata_lanes"}, 32'(wd_ok), 32'd1);
    end
    exp_rdata = exp_q.pop_front();
    check({tag, "_rdata"}, got_rdata, exp_rdata);
    check({tag, "_err"}, 32'(got_err), 32'(mis));

    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_idle"}, 32'(bus.req_ready), 32'd1);

    if (wr && !mis) ref_store(sz, addr, wd);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int seen_resp;
    mem_size_t sz;
    size_t addr;

    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 4; k++) ref_bytes[4*i + k] = init_word(i) >> (8*k);

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = BYTE;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_read", 32'(bus.avm_read), 32'd0);
    check("rst_write", 32'(bus.avm_write), 32'd0);
    check("rst_be", 32'(bus.avm_byteenable), 32'd0);
    check("rst_wdata", bus.avm_writedata, 32'd0);
    check("rst_addr", bus.avm_address, BASE);
    check("rst_resp", {bus.resp_valid, bus.resp_err}, 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'd0);
    rst = 1'b0;

    do_req("lw",   1'b0, WORD, 1'b0, BASE + 32'h4, 32'h0, 0);
    do_req("lb",   1'b0, BYTE, 1'b1, BASE + 32'h7, 32'h0, 0);
    do_req("lbu",  1'b0, BYTE, 1'b0, BASE + 32'h7, 32'h0, 0);
    do_req("sh",   1'b1, HALF, 1'b0, BASE + 32'h2, 32'h00001234, 0);
    do_req("lw2",  1'b0, WORD, 1'b0, BASE + 32'h0, 32'h0, 0);
    do_req("lhs",  1'b0, HALF, 1'b1, BASE + 32'h6, 32'h0, 0);
    do_req("lw_w", 1'b0, WORD, 1'b0, BASE + 32'h8, 32'h0, 3);
    do_req("mis",  1'b0, WORD, 1'b0, BASE + 32'h2, 32'h0, 0);
    do_req("mish", 1'b1, HALF, 1'b0, BASE + 32'h5, 32'hFFFF, 0);

    // Reset while the slave stalls a read.
    @(negedge clk);
    wait_cfg = 5;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = WORD;
    bus.req_signed = 1'b0; bus.req_addr = BASE + 32'hC; bus.req_wdata = '0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abort_read_on", 32'(bus.avm_read), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_read_off", 32'(bus.avm_read), 32'd0);
    check("abort_addr", bus.avm_address, BASE);
    seen_resp = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.resp_valid) seen_resp++;
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.resp_valid) seen_resp++;
    end
    check("abort_no_resp", 32'(seen_resp), 32'd0);
    check("abort_ready", 32'(bus.req_ready), 32'd1);

    // Randomized traffic, mostly aligned.
    for (int t = 0; t < 60; t++) begin
      sz = mem_size_t'($urandom_range(0, 2));
      addr = BASE + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(nbytes(sz) - 1);
      do_req($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             addr, $urandom, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_mem_master.md
Name: avalon_mem_master

Overview:
- Avalon-MM initiator between the CPU datapath and the memory slave (instruction/data RAM model, later a real bus).
- Takes one load/store request at a time, converts byte/half/word accesses into a word-aligned Avalon transfer with little-endian byteenable, and honours waitrequest.
- Captures readdata and returns it lane-extracted and sign/zero-extended.
- One outstanding transfer; no pipelining.

Parameters:
- RESET_ADDR, 32'hBFC00000, value driven on avm_address while idle and after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request strobe, sampled only when req_ready=1.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1=store, 0=load.
- req_size  in  mem_size_t  BYTE, HALF or WORD.
- req_signed  in  1  sign-extend load result (ignored for WORD and stores).
- req_addr  in  size_t  byte address.
- req_wdata  in  size_t  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse, request complete.
- resp_rdata  out  size_t  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned request, valid with resp_valid.
- avm_address  out  size_t  word-aligned address, {addr[31:2],2'b00}.
- avm_read  out  1  Avalon read.
- avm_write  out  1  Avalon write.
- avm_byteenable  out  4  lane enables; bit k covers writedata[8k+7:8k].
- avm_writedata  out  size_t  lane-shifted store data.
- avm_readdata  in  size_t  slave read data.
- avm_waitrequest  in  1  slave stall.

Behaviour:
- Reset is asynchronous. On reset the block enters IDLE and drives avm_read=0, avm_write=0, avm_byteenable=0, avm_writedata=0, avm_address=RESET_ADDR, resp_valid=0, resp_rdata=0 and resp_err=0. The same applies to a reset asserted mid-transfer: bus strobes drop immediately and no resp_valid is issued for the aborted request.
- FSM states are IDLE, BUS, RDATA and RESP. All request fields are latched on acceptance.
- IDLE:
  - req_ready=1.
  - req_valid=1 and aligned: go to BUS.
  - req_valid=1 and misaligned (HALF with addr[0]=1, or WORD with addr[1:0]!=0): go to RESP with resp_err=1. No bus strobe is ever asserted.
- BUS:
  - Assert exactly one of avm_read or avm_write, with address, byteenable and writedata held stable.
  - avm_waitrequest=1: stay in BUS and hold all outputs.
  - avm_waitrequest=0 on a write: go to RESP.
  - avm_waitrequest=0 on a read: go to RDATA.
  - Strobes deassert on leaving BUS.
- RDATA:
  - Strobes are low.
  - Capture avm_readdata at the end of this cycle, since the slave registers readdata one cycle after acceptance. Go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE. A new request can be accepted on the following cycle.
- Latency with waitrequest=0, counted from the acceptance edge: a read gives resp_valid 3 cycles later and a write 2 cycles later. Each waitrequest cycle adds one cycle.
- Byteenable generation, with a = addr[1:0]:
  - BYTE: 1<<a.
  - HALF: 4'b0011 if a=0, 4'b1100 if a=2.
  - WORD: 4'b1111.
- Write data: avm_writedata = req_wdata << (8*a). Unenabled lanes are don't-care; the bench checks only enabled lanes.
- Read extraction:
  - BYTE: readdata[8a+7:8a].
  - HALF: readdata[8a+15:8a].
  - Either is extended to 32 bits, with sign from its top bit when req_signed=1, otherwise zero-extended.
  - WORD: passthrough.
- Inputs arriving while req_ready=0 are ignored.

Decomposition:
- Add to package codes:
  - mem_size_t enum (BYTE=2'd0, HALF=2'd1, WORD=2'd2).
  - The FSM state enum.
  - Reuse the existing size_t.
- One combinational sub-module, mem_lane_align, holds the byteenable/writedata shift and read extract/extend logic, so the future load/store unit can share it.
- The FSM remains in avalon_mem_master.

Test Plan:
- LW from 0xBFC00004, RAM word 0x8899AABB, waitrequest=0 -> avm_read for exactly 1 cycle at 0xBFC00004 with be=1111; resp_valid 3 cycles after acceptance; rdata=0x8899AABB; err=0.
- LB signed and LBU from 0xBFC00007, same word -> be=1000; rdata=0xFFFFFF88 (signed) and 0x00000088 (unsigned).
- SH of 0x1234 to 0xBFC00002 -> avm_write for 1 cycle; be=1100; writedata[31:16]=0x1234; a following LW returns 0x1234xxxx with the lower half unchanged; store resp_valid 2 cycles after acceptance.
- LW with waitrequest held high for 3 cycles -> avm_read and address stable for 4 cycles; resp_valid 6 cycles after acceptance.
- LW to 0xBFC00002 (misaligned) -> avm_read/avm_write never assert; resp_valid with err=1 and rdata=0 one cycle after acceptance.
- Reset asserted during BUS with waitrequest=1 -> avm_read drops asynchronously; no resp_valid; req_ready=1 after reset is released.
